multicore_processor: RTL and testbench

//   Top level of a 4-core multiplier processor. Four identical accumulator cores run one shared program

---
 rtl/mcp_pkg.sv | 30 +++
 rtl/mcp_core.sv | 124 ++++++++++++
 rtl/multicore_processor.sv | 70 +++++++
 tb/tb_multicore_processor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared definitions for the 4-core accumulator/multiplier processor:
// opcode values, the core FSM state type and operand decoding.
package mcp_pkg;

    localparam logic [7:0] OP_NOP   = 8'd0;
    localparam logic [7:0] OP_LDI   = 8'd1;
    localparam logic [7:0] OP_LOAD  = 8'd2;
    localparam logic [7:0] OP_STORE = 8'd3;
    localparam logic [7:0] OP_ADD   = 8'd4;
    localparam logic [7:0] OP_MUL   = 8'd5;
    localparam logic [7:0] OP_MOV   = 8'd6;
    localparam logic [7:0] OP_JNZ   = 8'd7;
    localparam logic [7:0] OP_DEC   = 8'd8;
    localparam logic [7:0] OP_ENDOP = 8'd104;

    localparam int NUM_CORES = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        OPER  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Opcodes followed by an operand byte in the instruction stream.
    function automatic logic has_operand(input logic [7:0] opc);
        return (opc == OP_LDI) || (opc == OP_LOAD) || (opc == OP_STORE) || (opc == OP_JNZ);
    endfunction

endpackage

// File: rtl/mcp_core.sv
// One accumulator core: PC/IR/OP/ACC/R plus the FETCH/OPER/EXEC/HALT sequencer.
// Reads the shared ROM asynchronously and owns one port into its own
// DMEM partition (base = CORE_ID * PART_W).
module mcp_core
    import mcp_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int DATA_W  = 16,
    parameter int DMEM_AW = 8,
    parameter int PART_W  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [7:0]         imem_addr_o,
    input  logic [7:0]         imem_data_i,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic               dmem_we_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    output logic [7:0]         ir_o
);

    localparam logic [DMEM_AW-1:0] BASE = DMEM_AW'(CORE_ID * PART_W);

    state_e              state_q, state_d;
    logic [7:0]          pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          op_q, op_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   r_q, r_d;
    logic                store_req;

    // State register; reset returns the core to FETCH from any state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ENDOP seen at fetch parks the core in HALT until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (imem_data_i == OP_ENDOP) begin
                    state_d = HALT;
                end else if (has_operand(imem_data_i)) begin
                    state_d = OPER;
                end else begin
                    state_d = EXEC;
                end
            end
            OPER:    state_d = EXEC;
            EXEC:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Output/datapath decode: next values of the architectural registers and the store strobe.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        op_d      = op_q;
        acc_d     = acc_q;
        r_d       = r_q;
        store_req = 1'b0;
        case (state_q)
            FETCH: begin
                ir_d = imem_data_i;
                pc_d = pc_q + 8'd1;
            end
            OPER: begin
                op_d = imem_data_i;
                pc_d = pc_q + 8'd1;
            end
            EXEC: begin
                case (ir_q)
                    OP_LDI:   acc_d = {{(DATA_W-8){1'b0}}, op_q};
                    OP_LOAD:  acc_d = dmem_rdata_i;
                    OP_STORE: store_req = 1'b1;
                    OP_ADD:   acc_d = acc_q + r_q;
                    OP_MUL:   acc_d = acc_q * r_q;
                    OP_MOV:   r_d = acc_q;
                    OP_DEC:   r_d = r_q - DATA_W'(1);
                    OP_JNZ: begin
                        if (r_q != '0) begin
                            pc_d = op_q;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Architectural registers; HALT holds everything because the decode leaves them unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= '0;
            ir_q  <= '0;
            op_q  <= '0;
            acc_q <= '0;
            r_q   <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            op_q  <= op_d;
            acc_q <= acc_d;
            r_q   <= r_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign dmem_addr_o  = BASE + DMEM_AW'(op_q[5:0]);
    assign dmem_wdata_o = acc_q;
    // A STORE in EXEC is dropped when reset lands on the same edge.
    assign dmem_we_o    = store_req & ~rst_i;
    assign ir_o         = ir_q;

endmodule

// File: rtl/multicore_processor.sv
// Top level: shared instruction ROM, shared data memory split into four
// disjoint partitions, and four identical cores running the same program.
module multicore_processor
    import mcp_pkg::*;
#(
    parameter int    DATA_W     = 16,
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "imem.hex",
    parameter string DMEM_FILE  = "dmem.hex"
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] ins1,
    output logic [7:0] ins2,
    output logic [7:0] ins3,
    output logic [7:0] ins4
);

    localparam int DMEM_AW = $clog2(DMEM_DEPTH);
    localparam int PART_W  = DMEM_DEPTH / NUM_CORES;

    logic [7:0]        rom     [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem_q  [DMEM_DEPTH];

    logic [7:0]         imem_addr [NUM_CORES];
    logic [7:0]         imem_data [NUM_CORES];
    logic [DMEM_AW-1:0] dmem_addr [NUM_CORES];
    logic [DATA_W-1:0]  dmem_rdata[NUM_CORES];
    logic               dmem_we   [NUM_CORES];
    logic [DATA_W-1:0]  dmem_wdata[NUM_CORES];
    logic [7:0]         ir        [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        assign imem_data[k]  = rom[imem_addr[k]];
        assign dmem_rdata[k] = dmem_q[dmem_addr[k]];

        mcp_core #(
            .CORE_ID (k),
            .DATA_W  (DATA_W),
            .DMEM_AW (DMEM_AW),
            .PART_W  (PART_W)
        ) u_core (
            .clk_i        (clk),
            .rst_i        (rst),
            .imem_addr_o  (imem_addr[k]),
            .imem_data_i  (imem_data[k]),
            .dmem_addr_o  (dmem_addr[k]),
            .dmem_rdata_i (dmem_rdata[k]),
            .dmem_we_o    (dmem_we[k]),
            .dmem_wdata_o (dmem_wdata[k]),
            .ir_o         (ir[k])
        );
    end

    // Four write ports; partitions are disjoint so writes never collide. Not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CORES; k++) begin
            if (dmem_we[k]) begin
                dmem_q[dmem_addr[k]] <= dmem_wdata[k];
            end
        end
    end

    assign ins1 = ir[0];
    assign ins2 = ir[1];
    assign ins3 = ir[2];
    assign ins4 = ir[3];

endmodule

// File: tb/tb_multicore_processor.sv
// Bench for multicore_processor: programs are placed in the ROM and DMEM
// backdoor while reset is held, an instruction-level interpreter predicts
// final memory contents and the halt cycle of every core, and the DUT is
// compared against it.
module tb_multicore_processor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ins1, ins2, ins3, ins4;
    logic [7:0] ins_w [4];

    assign ins_w[0] = ins1;
    assign ins_w[1] = ins2;
    assign ins_w[2] = ins3;
    assign ins_w[3] = ins4;

    multicore_processor #(
        .IMEM_FILE (""),
        .DMEM_FILE ("")
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ins1 (ins1),
        .ins2 (ins2),
        .ins3 (ins3),
        .ins4 (ins4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rom_img [256];
    logic [15:0] m_dmem  [256];
    int          m_halt  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instruction-level interpreter: each core in turn, 2 cycles per plain
    // instruction, 3 per operand instruction, ENDOP counted at its fetch.
    task automatic model_run();
        for (int k = 0; k < 4; k++) begin
            logic [7:0]  pc, ir, op;
            logic [15:0] acc, r;
            int          cyc, addr;
            pc = 0; acc = 0; r = 0; op = 0; cyc = 0;
            m_halt[k] = -1;
            for (int step = 0; step < 5000; step++) begin
                ir = rom_img[pc];
                pc = pc + 8'd1;
                cyc++;
                if (ir == 8'd104) begin
                    m_halt[k] = cyc;
                    break;
                end
                if (ir == 8'd1 || ir == 8'd2 || ir == 8'd3 || ir == 8'd7) begin
                    op = rom_img[pc];
                    pc = pc + 8'd1;
                    cyc++;
                end
                cyc++;
                addr = k * 64 + int'(op % 8'd64);
                case (ir)
                    8'd1: acc = {8'h00, op};
                    8'd2: acc = m_dmem[addr];
                    8'd3: m_dmem[addr] = acc;
                    8'd4: acc = acc + r;
                    8'd5: acc = acc * r;
                    8'd6: r = acc;
                    8'd8: r = r - 16'd1;
                    8'd7: if (r != 0) pc = op;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic setup_images(input logic [7:0] prog[$]);
        for (int i = 0; i < 256; i++) begin
            rom_img[i] = (i < prog.size()) ? prog[i] : 8'd0;
            m_dmem[i]  = 16'($urandom);
        end
    endtask

    // Hold reset, push images into the DUT, check reset state, then predict.
    task automatic commit_and_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dut.rom[i]    = rom_img[i];
            dut.dmem_q[i] = m_dmem[i];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("%s_rst_ins%0d", tag, k), ins_w[k], 0);
        model_run();
    endtask

    task automatic run_and_check(input string tag);
        int seen [4];
        int cyc;
        bit done;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) seen[k] = -1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (seen[k] < 0 && ins_w[k] == 8'd104) seen[k] = cyc;
                if (seen[k] < 0) done = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) check($sformatf("%s_halt_cycle%0d", tag, k), seen[k], m_halt[k]);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("%s_hold%0d", tag, k), ins_w[k], 104);
        for (int i = 0; i < 256; i++) check($sformatf("%s_dmem%0d", tag, i), dut.dmem_q[i], m_dmem[i]);
    endtask

    function automatic void loop_prog(input logic [7:0] a, input logic [7:0] cnt, output logic [7:0] p[$]);
        p = '{8'd1, cnt, 8'd3, 8'd10, 8'd1, 8'd0, 8'd3, 8'd11,
              8'd1, a, 8'd6, 8'd2, 8'd11, 8'd4, 8'd3, 8'd11,
              8'd2, 8'd10, 8'd6, 8'd8, 8'd1, 8'd0, 8'd4, 8'd3, 8'd10,
              8'd7, 8'd8, 8'd2, 8'd11, 8'd3, 8'd12, 8'd104};
    endfunction

    initial begin
        logic [7:0]  p[$];
        logic [7:0]  ops_tbl [10];
        logic [15:0] a_v, b_v;
        logic [15:0] saved [4];

        ops_tbl = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd200, 8'd9};

        // Immediate ENDOP.
        p = '{8'd104};
        setup_images(p);
        commit_and_reset("endop");
        run_and_check("endop");

        // 7 * 6 = 42 in every partition.
        p = '{8'd1, 8'd7, 8'd6, 8'd1, 8'd6, 8'd5, 8'd3, 8'd0, 8'd104};
        setup_images(p);
        commit_and_reset("mul42");
        run_and_check("mul42");
        for (int k = 0; k < 4; k++) check($sformatf("mul42_word%0d", k), dut.dmem_q[k*64], 42);

        // Per-core operands from memory.
        p = '{8'd2, 8'd0, 8'd6, 8'd2, 8'd1, 8'd5, 8'd3, 8'd2, 8'd104};
        setup_images(p);
        for (int k = 0; k < 4; k++) begin
            a_v = (k == 0) ? 16'd3 : 16'($urandom);
            b_v = (k == 0) ? 16'd5 : 16'($urandom);
            m_dmem[k*64]   = a_v;
            m_dmem[k*64+1] = b_v;
        end
        commit_and_reset("loadmul");
        run_and_check("loadmul");
        check("loadmul_3x5", dut.dmem_q[2], 15);

        // Multiply by repeated addition: 9*4 then random factors.
        loop_prog(8'd9, 8'd4, p);
        setup_images(p);
        commit_and_reset("loop9x4");
        run_and_check("loop9x4");
        for (int k = 0; k < 4; k++) check($sformatf("loop9x4_res%0d", k), dut.dmem_q[k*64+12], 36);
        for (int t = 0; t < 2; t++) begin
            loop_prog(8'($urandom_range(1, 255)), 8'($urandom_range(1, 6)), p);
            setup_images(p);
            commit_and_reset("loop_rand");
            run_and_check("loop_rand");
        end

        // Reset mid-program, then full rerun.
        loop_prog(8'd9, 8'd4, p);
        setup_images(p);
        commit_and_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(3, 40)) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("midrst_ins%0d", k), ins_w[k], 0);
        run_and_check("midrst");

        // Reset on the STORE execute edge suppresses the write.
        p = '{8'd1, 8'd77, 8'd3, 8'd5, 8'd104};
        setup_images(p);
        for (int k = 0; k < 4; k++) saved[k] = m_dmem[k*64+5];
        commit_and_reset("stsup");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("stsup_ir%0d", k), ins_w[k], 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stsup_ins%0d", k), ins_w[k], 0);
            check($sformatf("stsup_kept%0d", k), dut.dmem_q[k*64+5], saved[k]);
        end
        run_and_check("stsup");

        // Overflow wrap with unknown opcodes 200 and 9 acting as NOP.
        p = '{8'd1, 8'd255, 8'd6, 8'd5, 8'd5, 8'd5, 8'd200, 8'd9, 8'd3, 8'd0, 8'd104};
        setup_images(p);
        commit_and_reset("wrap");
        run_and_check("wrap");

        // PC wrap 255 -> 0: second pass through address 0 takes the JNZ.
        p = '{8'd7, 8'd10, 8'd1, 8'd1, 8'd6, 8'd7, 8'd250};
        setup_images(p);
        rom_img[10]  = 8'd3;   rom_img[11]  = 8'd3;   rom_img[12] = 8'd104;
        rom_img[250] = 8'd1;   rom_img[251] = 8'd66;  rom_img[252] = 8'd0;
        rom_img[253] = 8'd200; rom_img[254] = 8'd0;   rom_img[255] = 8'd4;
        commit_and_reset("pcwrap");
        run_and_check("pcwrap");
        for (int k = 0; k < 4; k++) check($sformatf("pcwrap_res%0d", k), dut.dmem_q[k*64+3], 67);

        // Random straight-line programs.
        for (int t = 0; t < 3; t++) begin
            logic [7:0] opc;
            int n;
            p = {};
            n = $urandom_range(8, 30);
            for (int i = 0; i < n; i++) begin
                opc = ops_tbl[$urandom_range(0, 9)];
                p.push_back(opc);
                if (opc == 8'd1 || opc == 8'd2 || opc == 8'd3) p.push_back(8'($urandom));
            end
            p.push_back(8'd104);
            setup_images(p);
            commit_and_reset("randprog");
            run_and_check("randprog");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
